dma_ahb_arbiter: RTL and testbench

- Downstream of the dual TX/RX DMA controller.
- Merges the controller's two AHB master ports (TX descriptor/data fetch, RX descriptor/data write-back) onto a single AHB master port toward the system bus.
- Provides AHB-style request/grant arbitration, address-phase and data-phase ownership tracking, and response routing.
- A hold limit prevents one DMA channel from starving the other.

---
 rtl/dma_ahb_arbiter_pkg.sv | 29 ++
 rtl/dma_ahb_arbiter_rr_arb2.sv | 71 +++++++
 rtl/dma_ahb_arbiter.sv | 111 +++++++++++
 tb/tb_dma_ahb_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_ahb_arbiter_pkg.sv
// Shared AHB encodings and channel IDs for the
// TX/RX DMA bus arbiter.
package dma_ahb_arbiter_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1,
    HRESP_RETRY = 2'd2,
    HRESP_SPLIT = 2'd3
  } hresp_e;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic CH_TX = 1'b0;
  localparam logic CH_RX = 1'b1;

  function automatic logic is_active(logic [1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/dma_ahb_arbiter_rr_arb2.sv
// Two-way round-robin AHB grant logic with a
// per-owner hold counter to bound burst length.
module ahb_rr_arb2
  import dma_ahb_arbiter_pkg::*;
#(
  parameter int RX_PRIORITY = 1,
  parameter int MAX_HOLD    = 16,
  parameter int HOLD_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hready_i,
  input  logic              tx_req_i,
  input  logic              rx_req_i,
  input  logic              owner_i,
  input  logic [1:0]        htrans_i,
  output logic [1:0]        grant_o,
  output logic [HOLD_W-1:0] hold_cnt_o
);

  localparam logic [HOLD_W-1:0] MAX_H =
    HOLD_W'(MAX_HOLD);
  localparam logic RR_RST =
    (RX_PRIORITY != 0) ? CH_TX : CH_RX;

  logic [1:0]        grant_q, grant_d;
  logic              rr_last_q, rr_last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              cur_ch;
  logic              win_ch;
  logic              keep;

  always_comb begin
    cur_ch = grant_q[1];
    keep   = (htrans_i == HTRANS_SEQ) &&
             (hold_q < MAX_H);
    win_ch = cur_ch;
    unique case ({tx_req_i, rx_req_i})
      2'b10:   win_ch = CH_TX;
      2'b01:   win_ch = CH_RX;
      2'b11:   win_ch = keep ? owner_i : ~rr_last_q;
      default: win_ch = cur_ch;
    endcase
    grant_d   = win_ch ? 2'b10 : 2'b01;
    rr_last_d = (win_ch != cur_ch) ? win_ch
                                   : rr_last_q;
    // next address owner is the current grant
    hold_d = hold_q;
    if ((cur_ch != owner_i) ||
        (htrans_i == HTRANS_IDLE))
      hold_d = '0;
    else if (hold_q < MAX_H)
      hold_d = hold_q + HOLD_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_q   <= 2'b01;
      rr_last_q <= RR_RST;
      hold_q    <= '0;
    end else if (hready_i) begin
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      hold_q    <= hold_d;
    end
  end

  assign grant_o    = grant_q;
  assign hold_cnt_o = hold_q;

endmodule

// File: rtl/dma_ahb_arbiter.sv
// Merges the TX and RX DMA AHB master ports onto a
// single system-bus master with phase tracking.
module dma_ahb_arbiter
  import dma_ahb_arbiter_pkg::*;
#(
  parameter int RX_PRIORITY = 1,
  parameter int MAX_HOLD    = 16,
  parameter int HOLD_W      = 8
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        tx_hbusreq,
  input  logic [1:0]  tx_htrans,
  input  logic [29:0] tx_haddr,
  input  logic        tx_hwrite,
  input  logic [31:0] tx_hwdata,
  output logic        tx_hgrant,
  output logic        tx_hready,
  output logic [1:0]  tx_hresp,
  output logic [31:0] tx_hrdata,
  input  logic        rx_hbusreq,
  input  logic [1:0]  rx_htrans,
  input  logic [29:0] rx_haddr,
  input  logic        rx_hwrite,
  input  logic [31:0] rx_hwdata,
  output logic        rx_hgrant,
  output logic        rx_hready,
  output logic [1:0]  rx_hresp,
  output logic [31:0] rx_hrdata,
  output logic [1:0]  HTRANS,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP,
  input  logic [31:0] HRDATA
);

  logic              hmaster_q;
  logic              dmaster_q;
  logic              dvalid_q;
  logic [1:0]        grant;
  logic [HOLD_W-1:0] hold_cnt;

  ahb_rr_arb2 #(
    .RX_PRIORITY (RX_PRIORITY),
    .MAX_HOLD    (MAX_HOLD),
    .HOLD_W      (HOLD_W)
  ) u_arb (
    .clk_i      (HCLK),
    .rst_i      (HRESET),
    .hready_i   (HREADY),
    .tx_req_i   (tx_hbusreq),
    .rx_req_i   (rx_hbusreq),
    .owner_i    (hmaster_q),
    .htrans_i   (HTRANS),
    .grant_o    (grant),
    .hold_cnt_o (hold_cnt)
  );

  assign tx_hgrant = grant[0];
  assign rx_hgrant = grant[1];

  always_comb begin
    HTRANS = tx_htrans;
    HADDR  = {tx_haddr, 2'b00};
    HWRITE = tx_hwrite;
    HWDATA = tx_hwdata;
    if (hmaster_q == CH_RX) begin
      HTRANS = rx_htrans;
      HADDR  = {rx_haddr, 2'b00};
      HWRITE = rx_hwrite;
    end
    if (dmaster_q == CH_RX)
      HWDATA = rx_hwdata;
  end

  assign HSIZE  = HSIZE_WORD;
  assign HBURST = HBURST_SINGLE;

  assign tx_hready = HREADY;
  assign rx_hready = HREADY;
  assign tx_hrdata = HRDATA;
  assign rx_hrdata = HRDATA;

  assign tx_hresp =
    (dvalid_q && dmaster_q == CH_TX) ? HRESP
                                     : HRESP_OKAY;
  assign rx_hresp =
    (dvalid_q && dmaster_q == CH_RX) ? HRESP
                                     : HRESP_OKAY;

  // wait states freeze both pipeline phases
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hmaster_q <= CH_TX;
      dmaster_q <= CH_TX;
      dvalid_q  <= 1'b0;
    end else if (HREADY) begin
      hmaster_q <= grant[1];
      dmaster_q <= hmaster_q;
      dvalid_q  <= is_active(HTRANS);
    end
  end

  logic unused_ok;
  assign unused_ok = ^hold_cnt;

endmodule

// File: tb/tb_dma_ahb_arbiter.sv
// Directed bench for dma_ahb_arbiter with MAX_HOLD
// shortened to 4 to exercise the hold limit.
module tb_dma_ahb_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        tx_hbusreq, rx_hbusreq;
  logic [1:0]  tx_htrans, rx_htrans;
  logic [29:0] tx_haddr, rx_haddr;
  logic        tx_hwrite, rx_hwrite;
  logic [31:0] tx_hwdata, rx_hwdata;
  logic        tx_hgrant, rx_hgrant;
  logic        tx_hready, rx_hready;
  logic [1:0]  tx_hresp, rx_hresp;
  logic [31:0] tx_hrdata, rx_hrdata;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  int tests = 0;
  int failed = 0;

  dma_ahb_arbiter #(
    .RX_PRIORITY (1),
    .MAX_HOLD    (4),
    .HOLD_W      (8)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .tx_hbusreq (tx_hbusreq),
    .tx_htrans  (tx_htrans),
    .tx_haddr   (tx_haddr),
    .tx_hwrite  (tx_hwrite),
    .tx_hwdata  (tx_hwdata),
    .tx_hgrant  (tx_hgrant),
    .tx_hready  (tx_hready),
    .tx_hresp   (tx_hresp),
    .tx_hrdata  (tx_hrdata),
    .rx_hbusreq (rx_hbusreq),
    .rx_htrans  (rx_htrans),
    .rx_haddr   (rx_haddr),
    .rx_hwrite  (rx_hwrite),
    .rx_hwdata  (rx_hwdata),
    .rx_hgrant  (rx_hgrant),
    .rx_hready  (rx_hready),
    .rx_hresp   (rx_hresp),
    .rx_hrdata  (rx_hrdata),
    .HTRANS     (HTRANS),
    .HADDR      (HADDR),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HBURST     (HBURST),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP),
    .HRDATA     (HRDATA)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    tx_hbusreq = 0; rx_hbusreq = 0;
    tx_htrans = 2'd0; rx_htrans = 2'd0;
    tx_haddr = '0; rx_haddr = 30'h55;
    tx_hwrite = 0; rx_hwrite = 0;
    tx_hwdata = 32'h1111_1111;
    rx_hwdata = 32'h2222_2222;
    HREADY = 1; HRESP = 2'd1;
    HRDATA = 32'h0;
    tick(); tick();
    HRESET = 1'b0;
    #1;
    if ({tx_hgrant, rx_hgrant} !== 2'b10) begin
      $display("FAIL reset_grant got %b exp 10",
               {tx_hgrant, rx_hgrant});
      failed++;
    end
    tests++;
    if (HTRANS !== 2'd0 || HADDR !== 32'h0) begin
      $display("FAIL reset_bus got %h/%h exp 0/0",
               HTRANS, HADDR);
      failed++;
    end
    tests++;
    if ({tx_hresp, rx_hresp} !== 4'b0) begin
      $display("FAIL reset_hresp got %b exp 0000",
               {tx_hresp, rx_hresp});
      failed++;
    end
    tests++;
    if ({HSIZE, HBURST} !== 6'b010_000) begin
      $display("FAIL reset_consts got %b exp 010000",
               {HSIZE, HBURST});
      failed++;
    end
    tests++;
    HRESP = 2'd0;
  endtask

  task automatic test_rx_single();
    rx_hbusreq = 1; rx_htrans = 2'd2;
    rx_haddr = 30'h100; rx_hwrite = 1;
    rx_hwdata = 32'hA5A5_0001;
    tick();
    if ({tx_hgrant, rx_hgrant} !== 2'b01) begin
      $display("FAIL rx_grant got %b exp 01",
               {tx_hgrant, rx_hgrant});
      failed++;
    end
    tests++;
    tick();
    if (HADDR !== 32'h400 || HTRANS !== 2'd2 ||
        HWRITE !== 1'b1) begin
      $display("FAIL rx_addr got %h/%h/%b exp 400/2/1",
               HADDR, HTRANS, HWRITE);
      failed++;
    end
    tests++;
    rx_hbusreq = 0;
    tick();
    rx_htrans = 2'd0;
    HRDATA = 32'hDEAD_BEEF;
    #1;
    if (HWDATA !== 32'hA5A5_0001) begin
      $display("FAIL rx_wdata got %h exp a5a50001",
               HWDATA);
      failed++;
    end
    tests++;
    if (tx_hrdata !== 32'hDEAD_BEEF ||
        rx_hrdata !== 32'hDEAD_BEEF) begin
      $display("FAIL rdata_bcast got %h/%h exp deadbeef",
               tx_hrdata, rx_hrdata);
      failed++;
    end
    tests++;
    tick();
  endtask

  task automatic test_alternate();
    logic [1:0]  exp_g;
    logic [31:0] exp_a;
    tx_hbusreq = 1; rx_hbusreq = 1;
    tx_htrans = 2'd2; rx_htrans = 2'd2;
    tx_haddr = 30'h10; rx_haddr = 30'h20;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      exp_a = (i % 2 == 0) ? 32'h80 : 32'h40;
      if ({tx_hgrant, rx_hgrant} !== exp_g ||
          HADDR !== exp_a) begin
        $display("FAIL alt_%0d got %b/%h exp %b/%h",
                 i, {tx_hgrant, rx_hgrant}, HADDR,
                 exp_g, exp_a);
        failed++;
      end
      tests++;
    end
    tx_hbusreq = 0; rx_hbusreq = 0;
    tx_htrans = 2'd0; rx_htrans = 2'd0;
    tick(); tick();
  endtask

  task automatic test_hold();
    tx_hbusreq = 1;
    tick(); tick();
    tx_htrans = 2'd2;
    tick();
    tx_htrans = 2'd3; rx_hbusreq = 1;
    for (int b = 2; b <= 4; b++) begin
      tick();
      if ({tx_hgrant, rx_hgrant} !== 2'b10) begin
        $display("FAIL hold_keep_%0d got %b exp 10",
                 b, {tx_hgrant, rx_hgrant});
        failed++;
      end
      tests++;
    end
    if (dut.u_arb.hold_q !== 8'd4) begin
      $display("FAIL hold_cnt got %0d exp 4",
               dut.u_arb.hold_q);
      failed++;
    end
    tests++;
    tick();
    if ({tx_hgrant, rx_hgrant} !== 2'b01) begin
      $display("FAIL hold_move got %b exp 01",
               {tx_hgrant, rx_hgrant});
      failed++;
    end
    tests++;
    tx_hbusreq = 0; tx_htrans = 2'd0;
    rx_haddr = 30'h3;
    tick();
    if (HADDR !== 32'hC ||
        dut.u_arb.hold_q !== 8'd0) begin
      $display("FAIL hold_owner got %h/%0d exp c/0",
               HADDR, dut.u_arb.hold_q);
      failed++;
    end
    tests++;
    rx_hbusreq = 0;
    tick();
  endtask

  task automatic test_wait_state();
    tx_hbusreq = 1; tx_htrans = 2'd0;
    tx_haddr = 30'h40; rx_haddr = 30'h20;
    tx_hwdata = 32'h7777_0001;
    tick(); tick();
    tx_htrans = 2'd2; tx_hbusreq = 0;
    tick();
    tx_htrans = 2'd0; HREADY = 0;
    rx_hbusreq = 1;
    for (int w = 0; w < 3; w++) begin
      tick();
      if ({tx_hgrant, rx_hgrant} !== 2'b10 ||
          HADDR !== 32'h100 ||
          HWDATA !== 32'h7777_0001 ||
          {tx_hready, rx_hready} !== 2'b00) begin
        $display("FAIL wait_frz_%0d got %b/%h/%h exp 10/100/77770001",
                 w, {tx_hgrant, rx_hgrant}, HADDR,
                 HWDATA);
        failed++;
      end
      tests++;
    end
    HREADY = 1;
    tick();
    if ({tx_hgrant, rx_hgrant} !== 2'b01 ||
        HADDR !== 32'h100) begin
      $display("FAIL wait_grant got %b/%h exp 01/100",
               {tx_hgrant, rx_hgrant}, HADDR);
      failed++;
    end
    tests++;
    rx_hbusreq = 0;
    tick();
    if (HADDR !== 32'h80) begin
      $display("FAIL wait_owner got %h exp 80", HADDR);
      failed++;
    end
    tests++;
  endtask

  task automatic test_error();
    rx_htrans = 2'd2;
    tick();
    rx_htrans = 2'd0;
    HREADY = 0; HRESP = 2'd1;
    #1;
    if (rx_hresp !== 2'd1 || tx_hresp !== 2'd0) begin
      $display("FAIL err_cyc1 got %0d/%0d exp 1/0",
               rx_hresp, tx_hresp);
      failed++;
    end
    tests++;
    tick();
    HREADY = 1;
    #1;
    if (rx_hresp !== 2'd1 || tx_hresp !== 2'd0) begin
      $display("FAIL err_cyc2 got %0d/%0d exp 1/0",
               rx_hresp, tx_hresp);
      failed++;
    end
    tests++;
    tick();
    if (rx_hresp !== 2'd0) begin
      $display("FAIL err_done got %0d exp 0",
               rx_hresp);
      failed++;
    end
    tests++;
    HRESP = 2'd0;
  endtask

  task automatic test_reset_mid();
    tx_hbusreq = 1; tx_htrans = 2'd0;
    tick(); tick();
    tx_htrans = 2'd2;
    tick();
    tx_htrans = 2'd3; rx_hbusreq = 1;
    tick();
    HRESET = 1;
    tick();
    HRESET = 0; HRESP = 2'd1;
    #1;
    if ({tx_hresp, rx_hresp} !== 4'b0) begin
      $display("FAIL rst_mid_dvalid got %b exp 0000",
               {tx_hresp, rx_hresp});
      failed++;
    end
    tests++;
    if ({tx_hgrant, rx_hgrant} !== 2'b10 ||
        dut.u_arb.hold_q !== 8'd0) begin
      $display("FAIL rst_mid_state got %b/%0d exp 10/0",
               {tx_hgrant, rx_hgrant},
               dut.u_arb.hold_q);
      failed++;
    end
    tests++;
    HRESP = 2'd0;
    tx_hbusreq = 0; rx_hbusreq = 0;
    tx_htrans = 2'd0;
    tick();
  endtask

  initial begin
    test_reset();
    test_rx_single();
    test_alternate();
    test_hold();
    test_wait_state();
    test_error();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed",
             tests, failed);
    $finish;
  end

endmodule
